// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: fetch T0-T2, opcode latch, execute T3-T7, falling-edge state register.
// Optional retired-instruction counter enabled by `define CONTROL_SEQ_INSTR_COUNT_EN.
module control_sequencer #(
   parameter int OPW = 5
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        Stop,
   output logic        Run,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        MDMuxread,
   output logic        RAMread,
   output logic        RAMwrite,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlowin,
   output logic        Zlowout,
   output logic        CSEout,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        ADD,
   output logic        SUB,
   output logic        AND,
   output logic        OR,
   output logic        Illegal,
   output logic [31:0] instr_count
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
   } state_t;

   localparam logic [OPW-1:0] OP_LD   = 5'b00000;
   localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPW-1:0] OP_ST   = 5'b00010;
   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_AND  = 5'b00101;
   localparam logic [OPW-1:0] OP_OR   = 5'b00110;
   localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPW-1:0] OP_HALT = 5'b11011;

   state_t         state, next_state;
   logic [OPW-1:0] op_q;
   logic           is_reg_alu, is_imm_alu, is_ldi, is_ld, is_st, is_nop, is_halt;
   logic           sel_add, sel_sub, sel_and, sel_or;
   logic           unused_ir;

   // Only the opcode field steers sequencing; operand fields belong to the datapath.
   assign unused_ir = ^IR[31-OPW:0];

   assign is_reg_alu = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND) || (op_q == OP_OR);
   assign is_imm_alu = (op_q == OP_ADDI) || (op_q == OP_ANDI) || (op_q == OP_ORI);
   assign is_ldi     = (op_q == OP_LDI);
   assign is_ld      = (op_q == OP_LD);
   assign is_st      = (op_q == OP_ST);
   assign is_nop     = (op_q == OP_NOP);
   assign is_halt    = (op_q == OP_HALT);

   // Address arithmetic for the load/store family reuses the adder.
   assign sel_add = (op_q == OP_ADD) || (op_q == OP_ADDI) || is_ldi || is_ld || is_st;
   assign sel_sub = (op_q == OP_SUB);
   assign sel_and = (op_q == OP_AND) || (op_q == OP_ANDI);
   assign sel_or  = (op_q == OP_OR)  || (op_q == OP_ORI);

   // Falling-edge update keeps every strobe stable across the datapath's rising-edge capture.
   // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(negedge clock or negedge clear) begin
      if (!clear) begin
         state <= S_RESET;
         op_q  <= '0;
      end else begin
         state <= next_state;
         if (state == S_T2) op_q <= IR[31 -: OPW];
      end
   end

   // Stop is honoured only at an instruction boundary, i.e. on every would-be entry to T0.
   // NOTE: next_state gets a default first so no path through the case infers a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         S_RESET:  next_state = Stop ? S_HALTED : S_T0;
         S_T0:     next_state = S_T1;
         S_T1:     next_state = S_T2;
         S_T2:     next_state = S_T3;
         S_T3: begin
            if (is_halt)
               next_state = S_HALTED;
            else if (is_reg_alu || is_imm_alu || is_ldi || is_ld || is_st)
               next_state = S_T4;
            else
               next_state = Stop ? S_HALTED : S_T0;
         end
         S_T4:     next_state = S_T5;
         S_T5:     next_state = (is_ld || is_st) ? S_T6 : (Stop ? S_HALTED : S_T0);
         S_T6:     next_state = S_T7;
         S_T7:     next_state = Stop ? S_HALTED : S_T0;
         S_HALTED: next_state = S_HALTED;
         default:  next_state = S_RESET;
      endcase
   end

   always_comb begin
      Run = 1'b1;   Illegal = 1'b0;
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
      MDRin = 1'b0; MDRout = 1'b0; MDMuxread = 1'b0; RAMread = 1'b0; RAMwrite = 1'b0;
      IRin = 1'b0;  Yin = 1'b0; Zlowin = 1'b0; Zlowout = 1'b0; CSEout = 1'b0;
      Gra = 1'b0;   Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      ADD = 1'b0;   SUB = 1'b0; AND = 1'b0; OR = 1'b0;
      unique case (state)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
         S_T1: begin
            Zlowout = 1'b1; PCin = 1'b1; MDMuxread = 1'b1; RAMread = 1'b1; MDRin = 1'b1;
         end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: begin
            if (is_reg_alu || is_imm_alu) begin
               Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            end else if (is_ldi || is_ld || is_st) begin
               Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end else if (!is_nop && !is_halt) begin
               Illegal = 1'b1;
            end
         end
         S_T4: begin
            Zlowin = 1'b1;
            if (is_reg_alu) begin
               Grc = 1'b1; Rout = 1'b1;
            end else begin
               CSEout = 1'b1;
            end
            ADD = sel_add; SUB = sel_sub; AND = sel_and; OR = sel_or;
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (is_ld || is_st) begin
               MARin = 1'b1;
            end else begin
               Gra = 1'b1; Rin = 1'b1;
            end
         end
         S_T6: begin
            MDRin = 1'b1;
            if (is_st) begin
               Gra = 1'b1; Rout = 1'b1;
            end else begin
               MDMuxread = 1'b1; RAMread = 1'b1;
            end
         end
         S_T7: begin
            if (is_st) begin
               RAMwrite = 1'b1;
            end else begin
               MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
         end
         S_HALTED: Run = 1'b0;
         default: ;
      endcase
   end

`ifdef CONTROL_SEQ_INSTR_COUNT_EN
   logic        retire;
   logic [31:0] count_q;

   // Retirement is the exit from the last execute state of a defined opcode.
   assign retire = ((state == S_T5) && (is_reg_alu || is_imm_alu || is_ldi)) ||
                   (state == S_T7) ||
                   ((state == S_T3) && is_nop);

   always_ff @(negedge clock or negedge clear) begin
      if (!clear)      count_q <= '0;
      else if (retire) count_q <= count_q + 32'd1;
   end

   assign instr_count = count_q;
`else
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table of per-state expected strobes, scoreboard queue,
// plus hand-written reset-abort and halt sequences.
module tb_control_sequencer;

   logic        clock, clear, Stop;
   logic [31:0] IR, instr_count;
   logic Run, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite;
   logic IRin, Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc, Rin, Rout, BAout;
   logic ADD, SUB, AND, OR, Illegal;
   logic [25:0] outs;

   control_sequencer dut (
      .clock(clock), .clear(clear), .IR(IR), .Stop(Stop), .Run(Run),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
      .MDRin(MDRin), .MDRout(MDRout), .MDMuxread(MDMuxread), .RAMread(RAMread), .RAMwrite(RAMwrite),
      .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout), .CSEout(CSEout),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .Illegal(Illegal), .instr_count(instr_count)
   );

   assign outs = {Run, Illegal, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread,
                  RAMwrite, IRin, Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc, Rin, Rout, BAout,
                  ADD, SUB, AND, OR};

   localparam logic [25:0] M_RUN  = 26'd1 << 25, M_ILL  = 26'd1 << 24, M_PCO  = 26'd1 << 23;
   localparam logic [25:0] M_PCI  = 26'd1 << 22, M_INC  = 26'd1 << 21, M_MARI = 26'd1 << 20;
   localparam logic [25:0] M_MDRI = 26'd1 << 19, M_MDRO = 26'd1 << 18, M_MUX  = 26'd1 << 17;
   localparam logic [25:0] M_RD   = 26'd1 << 16, M_WR   = 26'd1 << 15, M_IRI  = 26'd1 << 14;
   localparam logic [25:0] M_YIN  = 26'd1 << 13, M_ZIN  = 26'd1 << 12, M_ZOUT = 26'd1 << 11;
   localparam logic [25:0] M_CSE  = 26'd1 << 10, M_GRA  = 26'd1 << 9,  M_GRB  = 26'd1 << 8;
   localparam logic [25:0] M_GRC  = 26'd1 << 7,  M_RIN  = 26'd1 << 6,  M_ROUT = 26'd1 << 5;
   localparam logic [25:0] M_BA   = 26'd1 << 4,  M_ADD  = 26'd1 << 3,  M_SUB  = 26'd1 << 2;
   localparam logic [25:0] M_AND  = 26'd1 << 1,  M_OR   = 26'd1 << 0;

`ifdef CONTROL_SEQ_INSTR_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam logic [31:0] IR_LDI  = 32'h0A00_0050, IR_ANDI = 32'h69A0_0053;
   localparam logic [31:0] IR_LD   = 32'h0080_0010, IR_ST   = 32'h1100_0020;
   localparam logic [31:0] IR_ADD  = 32'h1912_0000, IR_NOP  = 32'hD000_0000;
   localparam logic [31:0] IR_HALT = 32'hD800_0000, IR_BAD  = 32'hF800_0000;

   typedef struct {
      logic [31:0] ir;
      logic        stop;
      logic [25:0] exp;
      logic [31:0] cnt;
   } vec_t;

   vec_t        vecs[$];
   vec_t        sb[$];
   logic [31:0] model_cnt;
   int          n_vec, n_miss;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp,
                        input logic [31:0] act_cnt, input logic [31:0] exp_cnt);
      n_vec++;
      if (act !== exp || act_cnt !== exp_cnt) begin
         n_miss++;
         $display("FAIL %s: got strobes=%h count=%0d, expected strobes=%h count=%0d",
                  name, act, act_cnt, exp, exp_cnt);
      end
   endtask

   // Reference sequence for one instruction, built from the opcode alone.
   task automatic add_instr(input logic [31:0] ir, input int stop_from, input int max_rows);
      logic [25:0] ex[$];
      logic [4:0]  op;
      logic [25:0] alu;
      bit          retires;
      op = ir[31:27];
      retires = 1'b1;
      ex.push_back(M_RUN | M_PCO | M_MARI | M_INC | M_ZIN);
      ex.push_back(M_RUN | M_ZOUT | M_PCI | M_MUX | M_RD | M_MDRI);
      ex.push_back(M_RUN | M_MDRO | M_IRI);
      case (op)
         5'b00011, 5'b01100: alu = M_ADD;
         5'b00100:           alu = M_SUB;
         5'b00101, 5'b01101: alu = M_AND;
         5'b00110, 5'b01110: alu = M_OR;
         default:            alu = M_ADD;
      endcase
      case (op)
         5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
            ex.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
            ex.push_back(M_RUN | M_GRC | M_ROUT | alu | M_ZIN);
            ex.push_back(M_RUN | M_ZOUT | M_GRA | M_RIN);
         end
         5'b01100, 5'b01101, 5'b01110: begin
            ex.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
            ex.push_back(M_RUN | M_CSE | alu | M_ZIN);
            ex.push_back(M_RUN | M_ZOUT | M_GRA | M_RIN);
         end
         5'b00001, 5'b00000, 5'b00010: begin
            ex.push_back(M_RUN | M_GRB | M_BA | M_YIN);
            ex.push_back(M_RUN | M_CSE | M_ADD | M_ZIN);
            if (op == 5'b00001) begin
               ex.push_back(M_RUN | M_ZOUT | M_GRA | M_RIN);
            end else begin
               ex.push_back(M_RUN | M_ZOUT | M_MARI);
               if (op == 5'b00000) begin
                  ex.push_back(M_RUN | M_MUX | M_RD | M_MDRI);
                  ex.push_back(M_RUN | M_MDRO | M_GRA | M_RIN);
               end else begin
                  ex.push_back(M_RUN | M_GRA | M_ROUT | M_MDRI);
                  ex.push_back(M_RUN | M_WR);
               end
            end
         end
         5'b11010: ex.push_back(M_RUN);
         5'b11011: begin ex.push_back(M_RUN); retires = 1'b0; end
         default:  begin ex.push_back(M_RUN | M_ILL); retires = 1'b0; end
      endcase
      for (int i = 0; i < ex.size() && i < max_rows; i++)
         vecs.push_back('{ir: (i < 3) ? ir : ~ir, stop: (i >= stop_from), exp: ex[i], cnt: model_cnt});
      if (retires && CNT_EN && max_rows >= ex.size()) model_cnt = model_cnt + 32'd1;
   endtask

   task automatic add_halted(input int n);
      for (int i = 0; i < n; i++)
         vecs.push_back('{ir: IR_NOP, stop: 1'b0, exp: 26'd0, cnt: model_cnt});
   endtask

   // Entered just after a falling edge; leaves just after the falling edge following the last row.
   task automatic run_vecs(input string tag);
      vec_t got;
      for (int i = 0; i < vecs.size(); i++) begin
         IR   = vecs[i].ir;
         Stop = vecs[i].stop;
         sb.push_back(vecs[i]);
         @(posedge clock);
         got = sb.pop_front();
         check($sformatf("%s_row%0d", tag, i), outs, got.exp, instr_count, got.cnt);
         @(negedge clock); #1;
      end
      vecs.delete();
   endtask

   task automatic pulse_clear();
      clear = 1'b0;
      #1 check("clear_async", outs, M_RUN, instr_count, 32'd0);
      @(posedge clock);
      check("clear_held", outs, M_RUN, instr_count, 32'd0);
      #1 clear = 1'b1;
      @(negedge clock); #1;
      model_cnt = 32'd0;
   endtask

   initial begin
      n_vec = 0; n_miss = 0; model_cnt = 32'd0;
      clear = 1'b0; IR = 32'd0; Stop = 1'b0;
      repeat (2) @(posedge clock);
      check("reset_state", outs, M_RUN, instr_count, 32'd0);
      #1 clear = 1'b1;
      @(negedge clock); #1;

      // ADD fetched and decoded, then aborted by clear while in T4.
      add_instr(IR_ADD, 99, 4);
      run_vecs("add_part");
      check("add_t4", outs, M_RUN | M_GRC | M_ROUT | M_ADD | M_ZIN, instr_count, 32'd0);
      pulse_clear();

      add_instr(IR_LDI, 99, 99);
      add_instr(IR_ANDI, 99, 99);
      add_instr(IR_LD, 99, 99);
      add_instr(IR_ST, 99, 99);
      add_instr(IR_NOP, 99, 99);
      add_instr(IR_BAD, 99, 99);
      add_instr(IR_ADD, 4, 99);
      add_halted(3);
      run_vecs("mix");
      check("count_mix", outs, 26'd0, instr_count, CNT_EN ? 32'd6 : 32'd0);

      pulse_clear();
      add_instr(IR_LDI, 99, 99);
      add_instr(IR_ANDI, 99, 99);
      add_instr(IR_NOP, 99, 99);
      add_instr(IR_BAD, 99, 99);
      add_instr(IR_HALT, 99, 99);
      add_halted(3);
      run_vecs("cnt");
      check("count_final", outs, 26'd0, instr_count, CNT_EN ? 32'd3 : 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
